census_feed_ctrl: RTL and testbench
===================================

CENSUS_FEED_CTRL -- requirements
Module: census_feed_ctrl

Interface
REQ-001 Parameter ROW_SZ, default 320: pixels per row.
REQ-002 Parameter COL_SZ, default 240: rows per frame.
REQ-003 Parameter LAG, default 2*ROW_SZ+2: flush pixels required to drain the census window after the last real pixel.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that arms capture of one frame.
REQ-007 abort  input  1  one-cycle pulse that abandons the current frame.
REQ-008 src_pix  input  8  source pixel.
REQ-009 src_valid  input  1  src_pix is valid.
REQ-010 src_sof  input  1  marks the first pixel of a frame; qualified by src_valid.
REQ-011 src_ready  output  1  controller accepts the pixel this cycle.
REQ-012 cen_val  output  8  pixel to the census engine.
REQ-013 cen_x  output  10  column of cen_val.
REQ-014 cen_y  output  10  row of cen_val.
REQ-015 cen_vld  output  1  census shift enable, one pixel per high cycle.
REQ-016 cen_out_vld  input  1  census engine output-valid strobe.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-019 err_sof  output  1  one-cycle pulse on an unexpected SOF.
REQ-020 out_cnt  output  20  census outputs counted in the last completed frame.

Function
REQ-021 FSM states SHALL be IDLE, WAIT_SOF, STREAM, FLUSH, DONE.
REQ-022 IDLE: src_ready=0 and cen_vld=0; start SHALL move the FSM to WAIT_SOF.
REQ-023 WAIT_SOF: src_ready=1; pixels with src_sof=0 SHALL be consumed and discarded; a src_valid&src_sof pixel SHALL be issued at (0,0) and the FSM SHALL enter STREAM.
REQ-024 Accept SHALL mean src_valid&src_ready; each accepted pixel SHALL appear on cen_val/cen_x/cen_y with cen_vld=1 exactly one cycle later (registered outputs).
REQ-025 STREAM: src_ready=1; cen_vld SHALL be 0 in any cycle following a non-accept, and x/y SHALL hold.
REQ-026 Coordinates: x SHALL increment per issued pixel; at x=ROW_SZ-1, x SHALL wrap to 0 and y SHALL increment; at y=COL_SZ-1, y SHALL wrap to 0.
REQ-027 Accepting pixel (ROW_SZ-1, COL_SZ-1) SHALL move the FSM to FLUSH.
REQ-028 src_sof on an accepted pixel in STREAM SHALL pulse err_sof, reissue that pixel at (0,0), and keep the FSM in STREAM.
REQ-029 FLUSH: src_ready=0; exactly LAG pixels of value 0 SHALL be issued on consecutive cycles with cen_vld=1, continuing the coordinate sequence of REQ-026; the FSM SHALL then enter DONE.
REQ-030 DONE: frame_done SHALL be 1 for one cycle, out_cnt SHALL be loaded with the frame counter, and the FSM SHALL return to IDLE.
REQ-031 The frame counter SHALL clear on entry to WAIT_SOF, increment on each cen_out_vld from WAIT_SOF through DONE inclusive, and saturate at 2^20-1.
REQ-032 start SHALL be ignored when the FSM is not in IDLE.
REQ-033 abort SHALL return the FSM to IDLE next cycle from any state and SHALL NOT update out_cnt or pulse frame_done.
REQ-034 abort takes priority over start, sof, and end-of-flush in the same cycle.
REQ-035 The flush counter SHALL be sized to hold LAG, with $clog2(LAG+1) bits.

Reset
REQ-036 Reset SHALL force IDLE and clear x, y, and the counters.
REQ-037 Reset SHALL drive src_ready, cen_vld, busy, frame_done, and err_sof to 0, and cen_val, cen_x, cen_y, and out_cnt to 0.
REQ-038 Reset mid-frame SHALL drop the frame without a frame_done pulse.

Structure
REQ-039 The FSM state enum, the default ROW_SZ/COL_SZ, and the LAG derivation SHALL live in the shared package census_pkg.
REQ-040 The x/y wrap logic SHALL be a sub-module raster_xy_cnt (inputs: clear, advance; outputs: x, y, last).

Verification (ROW_SZ=8, COL_SZ=6, LAG=18)
REQ-041 Start, then 48 back-to-back pixels with SOF on the first -> 48 cen_vld cycles at (0,0)..(7,5), then 18 zero pixels at (0,0)..(1,2), then frame_done 1 cycle after the last flush pixel.
REQ-042 3 non-SOF pixels before SOF -> those 3 are discarded and the first cen_vld pixel is the SOF pixel at (0,0).
REQ-043 src_valid low for 5 cycles after pixel (3,2) -> cen_vld low for 5 cycles and the next pixel is issued at (4,2).
REQ-044 SOF at pixel 20 -> err_sof pulse, that pixel at (0,0), and frame_done only after 48 further pixels and the flush.
REQ-045 abort during FLUSH, and reset during STREAM -> IDLE, no frame_done, out_cnt unchanged by abort.
REQ-046 Drive cen_out_vld 48 times during a frame -> out_cnt=48 at frame_done; a start pulse while busy has no effect.

Source files
------------

// File: rtl/census_pkg.sv
// Shared definitions for the census feed controller: FSM states, default
// frame geometry and the flush-lag derivation.
package census_pkg;

  localparam int CENSUS_ROW_SZ = 320;
  localparam int CENSUS_COL_SZ = 240;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  // Two full rows plus two pixels push the last real pixel through a 3x3 window.
  function automatic int census_lag(input int row_sz);
    return 2 * row_sz + 2;
  endfunction

endpackage

// File: rtl/raster_xy_cnt.sv
// Raster coordinate counter: holds the (x, y) of the next pixel to issue and
// wraps column/row at the frame edges.
module raster_xy_cnt
  import census_pkg::*;
#(
  parameter int ROW_SZ = CENSUS_ROW_SZ,
  parameter int COL_SZ = CENSUS_COL_SZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       last
);

  localparam logic [9:0] X_MAX = 10'(ROW_SZ - 1);
  localparam logic [9:0] Y_MAX = 10'(COL_SZ - 1);

  logic [9:0] base_x;
  logic [9:0] base_y;

  // clear together with advance restarts at the origin and steps past it,
  // so the origin pixel itself is issued in the same cycle.
  always_comb begin
    base_x = clear ? 10'd0 : x;
    base_y = clear ? 10'd0 : y;
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (advance) begin
      if (base_x == X_MAX) begin
        x <= 10'd0;
        y <= (base_y == Y_MAX) ? 10'd0 : base_y + 10'd1;
      end else begin
        x <= base_x + 10'd1;
        y <= base_y;
      end
    end else begin
      x <= base_x;
      y <= base_y;
    end
  end

endmodule

// File: rtl/census_feed_ctrl.sv
// Feeds one frame of source pixels into a census engine with raster
// coordinates, then flushes the window with zero pixels.
module census_feed_ctrl
  import census_pkg::*;
#(
  parameter int ROW_SZ = CENSUS_ROW_SZ,
  parameter int COL_SZ = CENSUS_COL_SZ,
  parameter int LAG    = census_lag(ROW_SZ)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  src_pix,
  input  logic        src_valid,
  input  logic        src_sof,
  output logic        src_ready,
  output logic [7:0]  cen_val,
  output logic [9:0]  cen_x,
  output logic [9:0]  cen_y,
  output logic        cen_vld,
  input  logic        cen_out_vld,
  output logic        busy,
  output logic        frame_done,
  output logic        err_sof,
  output logic [19:0] out_cnt
);

  localparam int          FW          = (LAG > 0) ? $clog2(LAG + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(LAG - 1);
  localparam bit          ORIGIN_LAST = (ROW_SZ == 1) && (COL_SZ == 1);
  localparam state_t      END_STATE   = (LAG == 0) ? DONE : FLUSH;
  localparam logic [19:0] CNT_MAX     = 20'hFFFFF;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          issue;
  logic          issue_zero;
  logic          restart;
  logic          frame_clr;
  logic          sof_err;
  logic          done_fire;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          last;
  logic [FW-1:0] flush_cnt;
  logic [19:0]   frame_cnt;
  logic [19:0]   frame_cnt_nxt;

  assign src_ready = (state == WAIT_SOF) || (state == STREAM);
  assign busy      = (state != IDLE);
  assign accept    = src_valid && src_ready;

  raster_xy_cnt #(
    .ROW_SZ (ROW_SZ),
    .COL_SZ (COL_SZ)
  ) u_xy (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_clr || restart),
    .advance (issue),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides every other transition, including the end of flush.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_zero = 1'b0;
    restart    = 1'b0;
    frame_clr  = 1'b0;
    sof_err    = 1'b0;
    done_fire  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frame_clr = 1'b1;
            state_nxt = WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (accept && src_sof) begin
            issue     = 1'b1;
            restart   = 1'b1;
            state_nxt = ORIGIN_LAST ? END_STATE : STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            issue = 1'b1;
            if (src_sof) begin
              restart = 1'b1;
              sof_err = 1'b1;
              if (ORIGIN_LAST) state_nxt = END_STATE;
            end else if (last) begin
              state_nxt = END_STATE;
            end
          end
        end
        FLUSH: begin
          issue      = 1'b1;
          issue_zero = 1'b1;
          if (flush_cnt == FLUSH_LAST) state_nxt = DONE;
        end
        DONE: begin
          done_fire = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (frame_clr) begin
      frame_cnt_nxt = 20'd0;
    end else if (busy && cen_out_vld && (frame_cnt != CNT_MAX)) begin
      frame_cnt_nxt = frame_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
      frame_cnt <= 20'd0;
      out_cnt   <= 20'd0;
    end else begin
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      frame_cnt <= frame_cnt_nxt;
      if (done_fire) out_cnt <= frame_cnt_nxt;
    end
  end

  // Coordinates hold between issued pixels so a stalled stream keeps its place.
  always_ff @(posedge clk) begin
    if (reset) begin
      cen_val    <= 8'd0;
      cen_x      <= 10'd0;
      cen_y      <= 10'd0;
      cen_vld    <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      cen_vld    <= issue;
      frame_done <= done_fire;
      err_sof    <= sof_err;
      if (issue) begin
        cen_val <= issue_zero ? 8'd0 : src_pix;
        cen_x   <= restart ? 10'd0 : x;
        cen_y   <= restart ? 10'd0 : y;
      end
    end
  end

endmodule

// File: tb/tb_census_feed_ctrl.sv
// Self-checking bench for census_feed_ctrl on an 8x6 frame with a lag of 18,
// comparing every cycle against a pixel-index reference model.
module tb_census_feed_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 6;
  localparam int LAG  = 18;
  localparam int NPIX = ROW * COL;
  localparam int CMAX = 1048575;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  src_pix;
  logic        src_valid;
  logic        src_sof;
  logic        src_ready;
  logic [7:0]  cen_val;
  logic [9:0]  cen_x;
  logic [9:0]  cen_y;
  logic        cen_vld;
  logic        cen_out_vld;
  logic        busy;
  logic        frame_done;
  logic        err_sof;
  logic [19:0] out_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 hunting SOF, 2 streaming, 3 flushing, 4 finishing.
  int m_phase = 0;
  int m_idx   = 0;
  int m_flush = 0;
  int m_cnt   = 0;
  int m_out   = 0;
  int last_x  = 0;
  int last_y  = 0;
  int vld_seen  = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int first_idx = -1;
  int out_prev  = 0;

  census_feed_ctrl #(
    .ROW_SZ (ROW),
    .COL_SZ (COL),
    .LAG    (LAG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .src_pix     (src_pix),
    .src_valid   (src_valid),
    .src_sof     (src_sof),
    .src_ready   (src_ready),
    .cen_val     (cen_val),
    .cen_x       (cen_x),
    .cen_y       (cen_y),
    .cen_vld     (cen_vld),
    .cen_out_vld (cen_out_vld),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_sof     (err_sof),
    .out_cnt     (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input bit e_vld, input logic [7:0] e_val, input int e_idx,
                          input bit e_err, input bit e_done);
    int ex;
    int ey;
    checkOutput("cen_vld", 32'(cen_vld), 32'(e_vld));
    if (e_vld) begin
      ex = e_idx % ROW;
      ey = (e_idx / ROW) % COL;
      checkOutput("cen_val", 32'(cen_val), 32'(e_val));
      checkOutput("cen_x", 32'(cen_x), 32'(ex));
      checkOutput("cen_y", 32'(cen_y), 32'(ey));
      last_x = ex;
      last_y = ey;
    end else begin
      checkOutput("cen_x_hold", 32'(cen_x), 32'(last_x));
      checkOutput("cen_y_hold", 32'(cen_y), 32'(last_y));
    end
    checkOutput("err_sof", 32'(err_sof), 32'(e_err));
    checkOutput("frame_done", 32'(frame_done), 32'(e_done));
    checkOutput("busy", 32'(busy), 32'(m_phase != 0));
    checkOutput("src_ready", 32'(src_ready), 32'((m_phase == 1) || (m_phase == 2)));
    checkOutput("out_cnt", 32'(out_cnt), 32'(m_out));
    if (cen_vld) begin
      vld_seen++;
      if (first_idx < 0) first_idx = 32'(cen_x) + ROW * 32'(cen_y);
    end
    if (frame_done) done_seen++;
    if (err_sof) err_seen++;
  endtask

  // One clock: drive inputs, advance the model, let the edge pass, then compare.
  task automatic applyStimulus(input bit st, input bit ab, input bit v, input bit sf,
                               input logic [7:0] px, input bit cov);
    bit         e_vld  = 1'b0;
    bit         e_err  = 1'b0;
    bit         e_done = 1'b0;
    int         e_idx  = 0;
    logic [7:0] e_val  = 8'd0;
    start = st; abort = ab; src_valid = v; src_sof = sf; src_pix = px; cen_out_vld = cov;
    if (!ab && (m_phase != 0) && cov && (m_cnt < CMAX)) m_cnt++;
    if (ab) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (st) begin m_phase = 1; m_cnt = 0; end
        1: if (v && sf) begin
             e_vld = 1'b1; e_val = px; e_idx = 0; m_idx = 1; m_phase = 2;
           end
        2: if (v) begin
             e_vld = 1'b1; e_val = px;
             if (sf) begin
               e_err = 1'b1; e_idx = 0; m_idx = 1;
             end else begin
               e_idx = m_idx; m_idx++;
             end
             if (m_idx == NPIX) begin m_phase = 3; m_flush = LAG; end
           end
        3: begin
             e_vld = 1'b1; e_val = 8'd0; e_idx = m_idx; m_idx++; m_flush--;
             if (m_flush == 0) m_phase = 4;
           end
        4: begin e_done = 1'b1; m_out = m_cnt; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    checkAll(e_vld, e_val, e_idx, e_err, e_done);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'($urandom()), 0);
  endtask

  task automatic sendPixel(input bit sf, input bit rnd_gap, input bit cov);
    if (rnd_gap) begin
      int g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) applyStimulus(0, 0, 0, 0, 8'($urandom()), 0);
    end
    applyStimulus(0, 0, 1, sf, 8'($urandom()), cov);
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 0; abort = 0; src_valid = 0; src_sof = 0; src_pix = 8'd0; cen_out_vld = 0;
    m_phase = 0; m_idx = 0; m_cnt = 0; m_out = 0; last_x = 0; last_y = 0;
    @(posedge clk);
    #1;
    checkAll(1'b0, 8'd0, 0, 1'b0, 1'b0);
    checkOutput("reset_cen_val", 32'(cen_val), 32'd0);
    reset = 1'b0;
  endtask

  task automatic clearWindow();
    vld_seen = 0; done_seen = 0; err_seen = 0; first_idx = -1;
  endtask

  initial begin
    doReset();
    idleCycles(2);

    // Back-to-back frame with a census strobe per pixel and a stray start.
    clearWindow();
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < NPIX; i++)
      applyStimulus(i == 10, 0, 1, i == 0, 8'($urandom()), 1);
    idleCycles(LAG + 4);
    checkOutput("f1_vld_count", 32'(vld_seen), 32'(NPIX + LAG));
    checkOutput("f1_done_count", 32'(done_seen), 32'd1);
    checkOutput("f1_out_cnt", 32'(out_cnt), 32'd48);

    // Three leading non-SOF pixels, then a 5-cycle stall after pixel (3,2).
    clearWindow();
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'($urandom()), 0);
    for (int i = 0; i < NPIX; i++) begin
      applyStimulus(0, 0, 1, i == 0, 8'($urandom()), 0);
      if (i == 19) idleCycles(5);
    end
    idleCycles(LAG + 4);
    checkOutput("f2_first_idx", 32'(first_idx), 32'd0);
    checkOutput("f2_vld_count", 32'(vld_seen), 32'(NPIX + LAG));
    checkOutput("f2_out_cnt", 32'(out_cnt), 32'd0);

    // SOF reappears at pixel 20; 48 more pixels are then needed.
    clearWindow();
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 20; i++) sendPixel(i == 0, 1'b1, 1'($urandom()));
    sendPixel(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < NPIX; i++) sendPixel(1'b0, 1'b1, 1'($urandom()));
    idleCycles(LAG + 4);
    checkOutput("f3_err_count", 32'(err_seen), 32'd1);
    checkOutput("f3_done_count", 32'(done_seen), 32'd1);

    // Abort in the middle of the flush.
    clearWindow();
    out_prev = m_out;
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < NPIX; i++) sendPixel(i == 0, 1'b0, 1'b1);
    idleCycles(5);
    applyStimulus(0, 1, 0, 0, 8'd0, 0);
    idleCycles(LAG + 4);
    checkOutput("f4_done_count", 32'(done_seen), 32'd0);
    checkOutput("f4_out_cnt_kept", 32'(out_cnt), 32'(out_prev));

    // Reset while streaming drops the frame.
    clearWindow();
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 25; i++) sendPixel(i == 0, 1'b1, 1'b1);
    doReset();
    idleCycles(LAG + 4);
    checkOutput("f5_done_count", 32'(done_seen), 32'd0);

    // Fully randomised frame that runs to completion.
    clearWindow();
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 8'($urandom()), 1);
    for (int i = 0; i < NPIX; i++) sendPixel(i == 0, 1'b1, 1'($urandom()));
    idleCycles(LAG + 4);
    checkOutput("f6_done_count", 32'(done_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
